lcd_frame_stats: RTL and testbench
==================================

# lcd_frame_stats

Per-frame statistics monitor on the dual-pixel output stream of the LCD drive interface (out_valid, out_r0..out_b1 after brightness adjustment). Accumulates per-channel sums, luma min/max and a CRC-32 over each frame, snapshots them at frame end, and exposes them through a zero-wait AHB slave register file plus a level interrupt. It is passive: it never back-pressures the pixel stream.

## Interface
- W_ADDR, 32, AHB address width
- W_DATA, 32, AHB data width
- IMG_PIX_W, 8, bits per colour component
- W_PAIRS, 25, width of pair counters
- DEF_PAIRS, 196608, reset value of PAIR_COUNT (768x512/2)

- HCLK  in  1  clock
- HRESETn  in  1  asynchronous, active-low reset
- sl_HSEL, sl_HREADY, sl_HWRITE  in  1 each  AHB slave select, bus ready, write
- sl_HTRANS  in  2  AHB transfer type
- sl_HADDR  in  W_ADDR  register index = sl_HADDR[5:2]
- sl_HWDATA  in  W_DATA  write data (data phase)
- out_sl_HREADY  out  1  tied 1
- out_sl_HRESP  out  2  tied OKAY
- out_sl_HRDATA  out  W_DATA  read data
- in_valid  in  1  one pixel pair this cycle
- in_r0, in_g0, in_b0, in_r1, in_g1, in_b1  in  IMG_PIX_W each  pixel pair
- irq  out  1  frame-done interrupt, level

## Operation
- Registers (index): 0 CTRL {bit2 irq_en, bit1 clear (write-only, self-clearing, reads 0), bit0 enable}; 1 PAIR_COUNT[24:0]; 2 STATUS {[15:8] frame_cnt, bit0 done; write 1 to bit0 clears done}; 3 SUM_R; 4 SUM_G; 5 SUM_B; 6 CRC; 7 YMINMAX {[15:8] max_y, [7:0] min_y}; 8 LIVE_PAIRS (read-only live count). Other indices read 0, writes ignored. Regs 3-7 are snapshots of the last completed frame, read-only.
- Address phase accepted when sl_HSEL & sl_HREADY & HTRANS in {NONSEQ, SEQ}; index and HWRITE latched; write applied from sl_HWDATA next cycle; HRDATA combinational from latched index.
- Pair accepted when in_valid & enable & !clear_pulse. Per accepted pair: SUM_x += x0 + x1 (32-bit, wraps); y = (r + 2g + b) >> 2 per pixel (10-bit intermediate, 8-bit result); live min/max updated with both y; CRC-32 poly 0x04C11DB7, non-reflected, init 0xFFFFFFFF, no final XOR, 48 bits per pair fed MSB-first in byte order r0,g0,b0,r1,g1,b1; live count += 1.
- Frame end: accepted pair with live count + 1 == PAIR_COUNT. Snapshots load the updated values (final pair included); live sums 0, CRC 0xFFFFFFFF, min 0xFF, max 0x00, count 0; done <= 1; frame_cnt += 1 (8-bit wrap).
- PAIR_COUNT = 0: no frame end ever occurs; count wraps at 2^W_PAIRS.
- irq = done & irq_en.
- Clear: resets live state only; snapshots, done, frame_cnt untouched.

## Timing
- Reset: out_sl_HRDATA 0, irq 0, CTRL 0, PAIR_COUNT DEF_PAIRS, STATUS 0, snapshots 0, live min 0xFF / max 0x00 / CRC 0xFFFFFFFF / count 0.
- Latency: pair accepted at edge N visible in LIVE_PAIRS after N; frame-end snapshot, done and irq valid the cycle after the final pair's edge.
- Back-to-back: pair on the cycle after the final pair starts the next frame from fresh live state; no pair lost.
- Clear coincident with in_valid: clear wins, pair dropped.
- done W1C coincident with frame end: set wins, done stays 1.
- Enable deasserted mid-frame: accumulation pauses, live state held; resumes on re-enable.
- PAIR_COUNT written mid-frame: takes effect on next accepted pair's compare.
- Async reset mid-frame: all state to reset values immediately.

## Test plan
- Reset, read indices 0-8 -> CTRL 0, PAIR_COUNT 0x30000, all else 0; irq 0.
- PAIR_COUNT=4, CTRL=0x5, 4 pairs r=g=b=10 contiguous -> SUM_R=SUM_G=SUM_B=80, YMINMAX 0x0A0A, STATUS 0x0101, irq 1 one cycle after last pair.
- Two 4-pair frames, gapped valid then contiguous with no gap between frames; pixels r0=1..r1=255 mix -> second snapshot independent of first, frame_cnt 2, YMINMAX min/max match model.
- enable=0 with 3 pairs, then clear after 2 enabled pairs, then 4 pairs -> one frame end; sums cover only last 4 pairs.
- Write STATUS=1 on frame-end cycle -> done stays 1; later write STATUS=1 -> done 0, irq 0.
- 4-pair ramp frame (bytes 0x00..0x17) -> CRC equals software model; clear coincident with in_valid drops that pair.

Source files
------------

// File: rtl/lcd_frame_stats.sv
// lcd_frame_stats: per-frame pixel statistics (channel sums, luma min/max, CRC-32) with AHB register file and frame-done irq
// Ports: HCLK, HRESETn (async, active-low); sl_HSEL/HREADY/HWRITE/HTRANS/HADDR/HWDATA AHB slave inputs;
//        out_sl_HREADY/HRESP/HRDATA zero-wait OKAY responses and read data; in_valid + in_r0..in_b1 pixel pair stream;
//        irq level frame-done interrupt (done & irq_en).
module lcd_frame_stats #(
    parameter int W_ADDR    = 32,
    parameter int W_DATA    = 32,
    parameter int IMG_PIX_W = 8,
    parameter int W_PAIRS   = 25,
    parameter int DEF_PAIRS = 196608
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 sl_HSEL,
    input  logic                 sl_HREADY,
    input  logic                 sl_HWRITE,
    input  logic [1:0]           sl_HTRANS,
    input  logic [W_ADDR-1:0]    sl_HADDR,
    input  logic [W_DATA-1:0]    sl_HWDATA,
    output logic                 out_sl_HREADY,
    output logic [1:0]           out_sl_HRESP,
    output logic [W_DATA-1:0]    out_sl_HRDATA,
    input  logic                 in_valid,
    input  logic [IMG_PIX_W-1:0] in_r0,
    input  logic [IMG_PIX_W-1:0] in_g0,
    input  logic [IMG_PIX_W-1:0] in_b0,
    input  logic [IMG_PIX_W-1:0] in_r1,
    input  logic [IMG_PIX_W-1:0] in_g1,
    input  logic [IMG_PIX_W-1:0] in_b1,
    output logic                 irq
);
    function automatic logic [IMG_PIX_W-1:0] luma(input logic [IMG_PIX_W-1:0] r, g, b);
        logic [IMG_PIX_W+1:0] s;
        s = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
        return s[IMG_PIX_W+1:2];
    endfunction
    // Bit-serial, non-reflected CRC-32 over the pair, MSB of r0 first.
    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [6*IMG_PIX_W-1:0] d);
        logic [31:0] c;
        c = c_in;
        for (int i = 6*IMG_PIX_W-1; i >= 0; i--)
            c = {c[30:0], 1'b0} ^ ((c[31] ^ d[i]) ? 32'h04C11DB7 : 32'h0);
        return c;
    endfunction
    logic [3:0]           idx_q;
    logic                 wr_q, enable, irq_en, done;
    logic [W_PAIRS-1:0]   pair_count, cnt, ncnt;
    logic [7:0]           frame_cnt;
    logic [W_DATA-1:0]    sum_r, sum_g, sum_b, nsum_r, nsum_g, nsum_b;
    logic [W_DATA-1:0]    snap_r, snap_g, snap_b;
    logic [31:0]          crc, ncrc, snap_crc;
    logic [IMG_PIX_W-1:0] ymin, ymax, y0, y1, lo, hi, nmin, nmax, snap_min, snap_max;
    logic                 a_phase, wr_ctrl, wr_status, clear_pulse, accept, frame_end;
    logic                 unused_ok;
    assign out_sl_HREADY = 1'b1;
    assign out_sl_HRESP  = 2'b00;
    assign irq           = done & irq_en;
    assign unused_ok     = ^{sl_HADDR[W_ADDR-1:6], sl_HADDR[1:0], sl_HTRANS[0], sl_HWDATA[W_DATA-1:W_PAIRS]};
    // NONSEQ and SEQ are the only transfer types with bit 1 set.
    assign a_phase     = sl_HSEL & sl_HREADY & sl_HTRANS[1];
    assign wr_ctrl     = wr_q && idx_q == 4'd0;
    assign wr_status   = wr_q && idx_q == 4'd2;
    assign clear_pulse = wr_ctrl & sl_HWDATA[1];
    assign accept      = in_valid & enable & ~clear_pulse;
    assign y0          = luma(in_r0, in_g0, in_b0);
    assign y1          = luma(in_r1, in_g1, in_b1);
    assign lo          = y0 < y1 ? y0 : y1;
    assign hi          = y0 > y1 ? y0 : y1;
    assign nmin        = lo < ymin ? lo : ymin;
    assign nmax        = hi > ymax ? hi : ymax;
    assign nsum_r      = sum_r + W_DATA'(in_r0) + W_DATA'(in_r1);
    assign nsum_g      = sum_g + W_DATA'(in_g0) + W_DATA'(in_g1);
    assign nsum_b      = sum_b + W_DATA'(in_b0) + W_DATA'(in_b1);
    assign ncrc        = crc_step(crc, {in_r0, in_g0, in_b0, in_r1, in_g1, in_b1});
    assign ncnt        = cnt + 1'b1;
    // A zero PAIR_COUNT would otherwise match when the live count wraps.
    assign frame_end   = accept && pair_count != '0 && ncnt == pair_count;
    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            idx_q      <= '0;
            wr_q       <= 1'b0;
            enable     <= 1'b0;
            irq_en     <= 1'b0;
            pair_count <= W_PAIRS'(DEF_PAIRS);
            done       <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            wr_q <= a_phase & sl_HWRITE;
            if (a_phase) idx_q <= sl_HADDR[5:2];
            if (wr_ctrl) {irq_en, enable} <= {sl_HWDATA[2], sl_HWDATA[0]};
            if (wr_q && idx_q == 4'd1) pair_count <= sl_HWDATA[W_PAIRS-1:0];
            if (frame_end) frame_cnt <= frame_cnt + 1'b1;
            if (frame_end) done <= 1'b1;
            else if (wr_status && sl_HWDATA[0]) done <= 1'b0;
        end
    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            {sum_r, sum_g, sum_b, snap_r, snap_g, snap_b} <= '0;
            {snap_crc, snap_min, snap_max, ymax, cnt}      <= '0;
            crc  <= '1;
            ymin <= '1;
        end else if (clear_pulse || frame_end) begin
            if (frame_end) begin
                {snap_r, snap_g, snap_b} <= {nsum_r, nsum_g, nsum_b};
                {snap_crc, snap_min, snap_max} <= {ncrc, nmin, nmax};
            end
            {sum_r, sum_g, sum_b, ymax, cnt} <= '0;
            crc  <= '1;
            ymin <= '1;
        end else if (accept) begin
            {sum_r, sum_g, sum_b} <= {nsum_r, nsum_g, nsum_b};
            {crc, ymin, ymax, cnt} <= {ncrc, nmin, nmax, ncnt};
        end
    always_comb begin
        out_sl_HRDATA = '0;
        case (idx_q)
            4'd0:    out_sl_HRDATA = W_DATA'({irq_en, 1'b0, enable});
            4'd1:    out_sl_HRDATA = W_DATA'(pair_count);
            4'd2:    out_sl_HRDATA = W_DATA'({frame_cnt, 7'd0, done});
            4'd3:    out_sl_HRDATA = snap_r;
            4'd4:    out_sl_HRDATA = snap_g;
            4'd5:    out_sl_HRDATA = snap_b;
            4'd6:    out_sl_HRDATA = W_DATA'(snap_crc);
            4'd7:    out_sl_HRDATA = W_DATA'({snap_max, snap_min});
            4'd8:    out_sl_HRDATA = W_DATA'(cnt);
            default: out_sl_HRDATA = '0;
        endcase
    end
endmodule

// File: tb/tb_lcd_frame_stats.sv
// tb_lcd_frame_stats: directed self-checking bench for lcd_frame_stats
module tb_lcd_frame_stats;
    logic        HCLK = 1'b0, HRESETn = 1'b0;
    logic        sl_HSEL = 1'b0, sl_HREADY = 1'b1, sl_HWRITE = 1'b0;
    logic [1:0]  sl_HTRANS = 2'b00;
    logic [31:0] sl_HADDR = '0, sl_HWDATA = '0;
    logic        out_sl_HREADY;
    logic [1:0]  out_sl_HRESP;
    logic [31:0] out_sl_HRDATA;
    logic        in_valid = 1'b0;
    logic [7:0]  in_r0 = '0, in_g0 = '0, in_b0 = '0, in_r1 = '0, in_g1 = '0, in_b1 = '0;
    logic        irq;
    int          checks = 0, errors = 0;
    logic [31:0] exp_crc;

    lcd_frame_stats dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .sl_HSEL(sl_HSEL), .sl_HREADY(sl_HREADY), .sl_HWRITE(sl_HWRITE),
        .sl_HTRANS(sl_HTRANS), .sl_HADDR(sl_HADDR), .sl_HWDATA(sl_HWDATA),
        .out_sl_HREADY(out_sl_HREADY), .out_sl_HRESP(out_sl_HRESP), .out_sl_HRDATA(out_sl_HRDATA),
        .in_valid(in_valid),
        .in_r0(in_r0), .in_g0(in_g0), .in_b0(in_b0), .in_r1(in_r1), .in_g1(in_g1), .in_b1(in_b1),
        .irq(irq)
    );

    always #5 HCLK = ~HCLK;

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            if (c[31] != b[i]) c = (c << 1) ^ 32'h04C11DB7;
            else c = c << 1;
        end
        return c;
    endfunction

    function automatic logic [31:0] crc_pair(input logic [31:0] c, input logic [7:0] a, b, d, e, f, g);
        return crc_byte(crc_byte(crc_byte(crc_byte(crc_byte(crc_byte(c, a), b), d), e), f), g);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic addr_ph(input logic [3:0] idx, input logic w);
        sl_HSEL = 1'b1; sl_HTRANS = 2'b10; sl_HWRITE = w; sl_HADDR = {26'd0, idx, 2'b00};
    endtask

    task idle_bus;
        sl_HSEL = 1'b0; sl_HTRANS = 2'b00; sl_HWRITE = 1'b0;
    endtask

    task automatic wr(input logic [3:0] idx, input logic [31:0] data);
        addr_ph(idx, 1'b1);
        tick;
        idle_bus;
        sl_HWDATA = data;
        tick;
    endtask

    task automatic rd(input string tag, input logic [3:0] idx, input logic [31:0] exp);
        addr_ph(idx, 1'b0);
        tick;
        idle_bus;
        chk(tag, out_sl_HRDATA, exp);
    endtask

    task automatic set_px(input logic [7:0] a, b, d, e, f, g);
        in_valid = 1'b1;
        {in_r0, in_g0, in_b0, in_r1, in_g1, in_b1} = {a, b, d, e, f, g};
    endtask

    task automatic px(input logic [7:0] a, b, d, e, f, g);
        set_px(a, b, d, e, f, g);
        tick;
        in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] rst_exp [0:8];
        rst_exp = '{32'h0, 32'h30000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        tick;
        tick;
        HRESETn = 1'b1;
        tick;
        // reset state
        for (int i = 0; i < 9; i++) rd($sformatf("reset_reg%0d", i), 4'(i), rst_exp[i]);
        rd("reset_reg15", 4'd15, 32'h0);
        chk("reset_irq", {31'd0, irq}, 32'h0);
        chk("hready", {31'd0, out_sl_HREADY}, 32'h1);
        chk("hresp", {30'd0, out_sl_HRESP}, 32'h0);

        // basic 4-pair frame, flat grey 10
        wr(4'd1, 32'd4);
        wr(4'd0, 32'h5);
        rd("ctrl_en", 4'd0, 32'h5);
        px(10, 10, 10, 10, 10, 10);
        px(10, 10, 10, 10, 10, 10);
        px(10, 10, 10, 10, 10, 10);
        chk("irq_before_end", {31'd0, irq}, 32'h0);
        px(10, 10, 10, 10, 10, 10);
        chk("irq_after_end", {31'd0, irq}, 32'h1);
        rd("f1_sum_r", 4'd3, 32'd80);
        rd("f1_sum_g", 4'd4, 32'd80);
        rd("f1_sum_b", 4'd5, 32'd80);
        rd("f1_yminmax", 4'd7, 32'h0A0A);
        rd("f1_status", 4'd2, 32'h0101);
        rd("f1_live", 4'd8, 32'h0);

        // asynchronous reset in the middle of a frame
        px(1, 1, 1, 1, 1, 1);
        px(1, 1, 1, 1, 1, 1);
        rd("mid_live", 4'd8, 32'd2);
        #3 HRESETn = 1'b0;
        #1 chk("areset_irq", {31'd0, irq}, 32'h0);
        tick;
        HRESETn = 1'b1;
        tick;
        rd("areset_live", 4'd8, 32'h0);
        rd("areset_pairs", 4'd1, 32'h30000);
        rd("areset_status", 4'd2, 32'h0);
        rd("areset_sum_r", 4'd3, 32'h0);

        // frame A gapped, frame B contiguous right after A
        wr(4'd1, 32'd4);
        wr(4'd0, 32'h5);
        px(1, 2, 3, 4, 5, 6);
        tick;
        px(10, 20, 30, 40, 50, 60);
        tick;
        tick;
        px(100, 0, 0, 0, 0, 200);
        tick;
        px(255, 255, 255, 128, 64, 32);
        chk("fa_irq", {31'd0, irq}, 32'h1);
        px(50, 50, 50, 60, 60, 60);
        px(70, 80, 90, 7, 7, 7);
        px(200, 100, 0, 30, 30, 30);
        px(1, 1, 1, 255, 0, 255);
        rd("fb_sum_r", 4'd3, 32'd673);
        rd("fb_sum_g", 4'd4, 32'd328);
        rd("fb_sum_b", 4'd5, 32'd493);
        rd("fb_yminmax", 4'd7, 32'h7F01);
        rd("fb_status", 4'd2, 32'h0201);
        exp_crc = crc_pair(32'hFFFFFFFF, 50, 50, 50, 60, 60, 60);
        exp_crc = crc_pair(exp_crc, 70, 80, 90, 7, 7, 7);
        exp_crc = crc_pair(exp_crc, 200, 100, 0, 30, 30, 30);
        exp_crc = crc_pair(exp_crc, 1, 1, 1, 255, 0, 255);
        rd("fb_crc", 4'd6, exp_crc);

        // enable off, then clear after two enabled pairs, then a clean frame
        wr(4'd2, 32'h1);
        rd("w1c_status", 4'd2, 32'h0200);
        wr(4'd0, 32'h4);
        px(100, 100, 100, 100, 100, 100);
        px(100, 100, 100, 100, 100, 100);
        px(100, 100, 100, 100, 100, 100);
        rd("dis_live", 4'd8, 32'h0);
        wr(4'd0, 32'h5);
        px(100, 100, 100, 100, 100, 100);
        px(100, 100, 100, 100, 100, 100);
        rd("en_live", 4'd8, 32'd2);
        wr(4'd0, 32'h7);
        rd("clr_live", 4'd8, 32'h0);
        rd("clr_ctrl", 4'd0, 32'h5);
        rd("clr_status", 4'd2, 32'h0200);
        for (int i = 0; i < 4; i++) px(1, 2, 3, 4, 5, 6);
        rd("fc_status", 4'd2, 32'h0301);
        rd("fc_sum_r", 4'd3, 32'd20);
        rd("fc_sum_g", 4'd4, 32'd28);
        rd("fc_sum_b", 4'd5, 32'd36);
        rd("fc_yminmax", 4'd7, 32'h0502);

        // done W1C on the frame-end cycle: set wins
        wr(4'd2, 32'h1);
        chk("w1c_irq", {31'd0, irq}, 32'h0);
        px(0, 0, 0, 0, 0, 0);
        px(0, 0, 0, 0, 0, 0);
        px(0, 0, 0, 0, 0, 0);
        addr_ph(4'd2, 1'b1);
        tick;
        idle_bus;
        sl_HWDATA = 32'h1;
        set_px(0, 0, 0, 0, 0, 0);
        tick;
        in_valid = 1'b0;
        chk("coinc_irq", {31'd0, irq}, 32'h1);
        rd("coinc_status", 4'd2, 32'h0401);
        wr(4'd2, 32'h1);
        rd("late_w1c_status", 4'd2, 32'h0400);
        chk("late_w1c_irq", {31'd0, irq}, 32'h0);

        // clear coincident with a valid pair drops it; then ramp frame CRC
        px(8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA);
        rd("pre_clr_live", 4'd8, 32'd1);
        addr_ph(4'd0, 1'b1);
        tick;
        idle_bus;
        sl_HWDATA = 32'h7;
        set_px(8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55);
        tick;
        in_valid = 1'b0;
        rd("drop_live", 4'd8, 32'h0);
        exp_crc = 32'hFFFFFFFF;
        for (int k = 0; k < 4; k++) begin
            px(8'(6*k), 8'(6*k+1), 8'(6*k+2), 8'(6*k+3), 8'(6*k+4), 8'(6*k+5));
            exp_crc = crc_pair(exp_crc, 8'(6*k), 8'(6*k+1), 8'(6*k+2), 8'(6*k+3), 8'(6*k+4), 8'(6*k+5));
        end
        rd("ramp_crc", 4'd6, exp_crc);
        rd("ramp_sum_r", 4'd3, 32'd84);
        rd("ramp_yminmax", 4'd7, 32'h1601);
        rd("ramp_status", 4'd2, 32'h0501);

        // PAIR_COUNT 0: never ends a frame
        wr(4'd1, 32'd0);
        for (int i = 0; i < 5; i++) px(3, 3, 3, 3, 3, 3);
        rd("pc0_live", 4'd8, 32'd5);
        rd("pc0_status", 4'd2, 32'h0501);
        rd("pc0_sum_r", 4'd3, 32'd84);
        rd("unmapped", 4'd9, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
